rs485_cmd_master: RTL

//  Initiator end of the RS485 key/LED link: sends one 8N1 command byte {4'b0,led_pattern} on the bus,

---
 rtl/rs485_cmd_master_if.sv | 27 ++
 rtl/rs485_cmd_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs485_cmd_master_if.sv
// Command/response and transceiver-pin bundle for the RS485 command master.
// The master modport is the controller's view; slave is the host/transceiver side.
interface rs485_cmd_master_if;
  logic       cmd_valid;
  logic [3:0] cmd_data;
  logic       cmd_ready;
  logic       rs485_uart_txd;
  logic       rs485_de;
  logic       rs485_uart_rxd;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       busy;

  modport master (
    input  cmd_valid, cmd_data, rs485_uart_rxd,
    output cmd_ready, rs485_uart_txd, rs485_de,
    output rsp_valid, rsp_data, rsp_err, rsp_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_data, rs485_uart_rxd,
    input  cmd_ready, rs485_uart_txd, rs485_de,
    input  rsp_valid, rsp_data, rsp_err, rsp_timeout, busy
  );
endinterface

// File: rtl/rs485_cmd_master.sv
// RS485 initiator: sends one 8N1 command byte {4'b0,cmd_data}, turns the
// half-duplex line around and receives the 8N1 key-data reply byte.
module rs485_cmd_master #(
  parameter int CLK_FREQ          = 50000000,
  parameter int UART_BPS          = 115200,
  parameter int TURN_GUARD_BITS   = 1,
  parameter int RESP_TIMEOUT_BITS = 20
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  rs485_cmd_master_if.master bus
);

  localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT  = BPS_CNT / 2;
  localparam int GUARD_CNT = TURN_GUARD_BITS * BPS_CNT;
  localparam int TMO_CNT   = RESP_TIMEOUT_BITS * BPS_CNT;
  localparam int MAX_A     = (BPS_CNT > GUARD_CNT) ? BPS_CNT : GUARD_CNT;
  localparam int MAX_CNT   = (MAX_A > TMO_CNT) ? MAX_A : TMO_CNT;
  localparam int CNT_W     = $clog2(MAX_CNT + 1);
  localparam bit HAS_GUARD = (TURN_GUARD_BITS > 0);

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] BPS_LAST   = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CNT - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_CNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DE_SETUP = 3'd1,
    ST_TX       = 3'd2,
    ST_GUARD    = 3'd3,
    ST_WAIT_RSP = 3'd4,
    ST_RX       = 3'd5
  } state_t;

  // Line level of 8N1 slot idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [3:0] nib, input logic [3:0] idx);
    logic [9:0] frame;
    frame = {1'b1, 4'b0000, nib, 1'b0};
    if (idx <= 4'd9) begin
      return frame[idx];
    end else begin
      return 1'b1;
    end
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] tmo_r, tmo_s;
  logic [3:0]       bit_r, bit_s;
  logic [3:0]       cmd_r, cmd_s;
  logic [7:0]       rx_byte_r, rx_byte_s;
  logic [3:0]       rsp_data_r, rsp_data_s;
  logic             rsp_valid_r, rsp_valid_s;
  logic             rsp_err_r, rsp_err_s;
  logic             rsp_tmo_r, rsp_tmo_s;
  logic             txd_r, de_r, ready_r, busy_r;
  logic             rx_meta_r, rx_sync_r, rx_prev_r;
  logic             rx_fall_s;
  logic             sample_s;

  assign rx_fall_s = rx_prev_r & ~rx_sync_r;

  // Two-flop synchronizer for the asynchronous receive line plus edge history
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= bus.rs485_uart_rxd;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Next-state, bit/baud/timeout counter and response computation
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    tmo_s       = tmo_r;
    bit_s       = bit_r;
    cmd_s       = cmd_r;
    rx_byte_s   = rx_byte_r;
    rsp_data_s  = rsp_data_r;
    rsp_valid_s = 1'b0;
    rsp_err_s   = 1'b0;
    rsp_tmo_s   = 1'b0;
    sample_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        bit_s = 4'd0;
        if (bus.cmd_valid && ready_r) begin
          cmd_s   = bus.cmd_data;
          state_s = ST_DE_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DE_SETUP: begin
        if (cnt_r == BPS_LAST) begin
          cnt_s   = CNT_ZERO;
          bit_s   = 4'd0;
          state_s = ST_TX;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_TX: begin
        if (cnt_r == BPS_LAST) begin
          cnt_s = CNT_ZERO;
          if (bit_r == 4'd9) begin
            bit_s   = 4'd0;
            tmo_s   = CNT_ZERO;
            state_s = HAS_GUARD ? ST_GUARD : ST_WAIT_RSP;
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_GUARD: begin
        if (cnt_r == GUARD_LAST) begin
          cnt_s   = CNT_ZERO;
          tmo_s   = CNT_ZERO;
          state_s = ST_WAIT_RSP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_RSP: begin
        if (tmo_r == TMO_LAST) begin
          rsp_tmo_s = 1'b1;
          state_s   = ST_IDLE;
        end else if (rx_fall_s) begin
          cnt_s   = CNT_ZERO;
          bit_s   = 4'd0;
          state_s = ST_RX;
        end else begin
          tmo_s = tmo_r + CNT_ONE;
        end
      end
      ST_RX: begin
        // Start bit is checked at half a bit, later slots one full bit apart.
        sample_s = (bit_r == 4'd0) ? (cnt_r == HALF_LAST) : (cnt_r == BPS_LAST);
        if (sample_s) begin
          cnt_s = CNT_ZERO;
          if (bit_r == 4'd0) begin
            if (rx_sync_r) begin
              state_s = ST_WAIT_RSP;
            end else begin
              bit_s = 4'd1;
            end
          end else if (bit_r == 4'd9) begin
            rsp_valid_s = 1'b1;
            rsp_err_s   = ~rx_sync_r | (rx_byte_r[7:4] != 4'b0000);
            rsp_data_s  = rx_byte_r[3:0];
            state_s     = ST_IDLE;
          end else begin
            rx_byte_s = {rx_sync_r, rx_byte_r[7:1]};
            bit_s     = bit_r + 4'd1;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs (outputs follow the next state)
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      tmo_r       <= CNT_ZERO;
      bit_r       <= 4'd0;
      cmd_r       <= 4'd0;
      rx_byte_r   <= 8'd0;
      rsp_data_r  <= 4'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_tmo_r   <= 1'b0;
      txd_r       <= 1'b1;
      de_r        <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      tmo_r       <= tmo_s;
      bit_r       <= bit_s;
      cmd_r       <= cmd_s;
      rx_byte_r   <= rx_byte_s;
      rsp_data_r  <= rsp_data_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_tmo_r   <= rsp_tmo_s;
      txd_r       <= (state_s == ST_TX) ? frame_bit(cmd_s, bit_s) : 1'b1;
      de_r        <= (state_s == ST_DE_SETUP) || (state_s == ST_TX) || (state_s == ST_GUARD);
      ready_r     <= (state_s == ST_IDLE);
      busy_r      <= (state_s != ST_IDLE);
    end
  end

  assign bus.cmd_ready      = ready_r;
  assign bus.rs485_uart_txd = txd_r;
  assign bus.rs485_de       = de_r;
  assign bus.rsp_valid      = rsp_valid_r;
  assign bus.rsp_data       = rsp_data_r;
  assign bus.rsp_err        = rsp_err_r;
  assign bus.rsp_timeout    = rsp_tmo_r;
  assign bus.busy           = busy_r;

endmodule
